// File: rtl/ir_frame_tx_if.sv
// Frame request handshake between the PS register block and ir_frame_tx.
interface ir_frame_tx_if #(
  parameter int unsigned SEG0_W = 35,
  parameter int unsigned SEG1_W = 32
);
  logic              tx_valid;
  logic              tx_ready;
  logic [SEG0_W-1:0] seg0_data;
  logic [SEG1_W-1:0] seg1_data;
  logic              tx_abort;

  modport master (output tx_valid, seg0_data, seg1_data, tx_abort, input tx_ready);
  modport slave  (input tx_valid, seg0_data, seg1_data, tx_abort, output tx_ready);
endinterface

// File: rtl/ir_frame_tx.sv
// Pulse-distance IR frame transmitter: header, SEG0, optional connect + SEG1, trailer.
// Define IR_FRAME_TX_CARRIER_EN to gate the envelope with the internal carrier.
module ir_frame_tx #(
  parameter int unsigned CARRIER_DIV  = 2631,
  parameter int unsigned CARRIER_HIGH = 1316,
  parameter int unsigned HDR_MARK     = 900000,
  parameter int unsigned HDR_SPACE    = 450000,
  parameter int unsigned BIT_MARK     = 60000,
  parameter int unsigned ZERO_SPACE   = 60000,
  parameter int unsigned ONE_SPACE    = 160000,
  parameter int unsigned CONN_MARK    = 60000,
  parameter int unsigned CONN_SPACE   = 2000000,
  parameter int unsigned TRAIL_MARK   = 60000,
  parameter int unsigned SEG0_BITS    = 35,
  parameter int unsigned SEG1_BITS    = 32
) (
  input  logic         clk,
  input  logic         rst,
  ir_frame_tx_if.slave tx,
  output logic         busy,
  output logic         done,
  output logic         envelope,
  output logic         IR_out
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned SEG1_W  = (SEG1_BITS == 0) ? 1 : SEG1_BITS;
  localparam int unsigned MAX_LEN = max2(max2(max2(HDR_MARK, HDR_SPACE), max2(BIT_MARK, ZERO_SPACE)),
                                         max2(max2(ONE_SPACE, CONN_MARK), max2(CONN_SPACE, TRAIL_MARK)));
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W   = 7;

  if (CARRIER_DIV < 2 || CARRIER_HIGH < 1 || CARRIER_HIGH >= CARRIER_DIV ||
      SEG0_BITS < 1 || SEG0_BITS > 64 || SEG1_BITS > 64) begin : g_param_check
    $error("ir_frame_tx: illegal parameter set");
  end

  // Phase counter holds remaining cycles minus one.
  function automatic logic [CNT_W-1:0] reload(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SEG0, S_CONNECT, S_SEG1, S_TRAILER
  } state_t;

  state_t                 state_q, state_n;
  logic                   space_q, space_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [SEG0_BITS-1:0]   seg0_q, seg0_n;
  logic [SEG1_W-1:0]      seg1_q, seg1_n;
  logic                   env_n, done_n, ir_n, accept_c, cur_bit_c;
  logic                   ready_q;

  assign tx.tx_ready = ready_q;

  always_comb begin
    state_n   = state_q;
    space_n   = space_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    seg0_n    = seg0_q;
    seg1_n    = seg1_q;
    env_n     = envelope;
    done_n    = 1'b0;
    accept_c  = 1'b0;
    cur_bit_c = (state_q == S_SEG1) ? seg1_q[SEG1_W-1] : seg0_q[SEG0_BITS-1];

    if (state_q == S_IDLE) begin
      if (tx.tx_valid) begin
        accept_c = 1'b1;
        state_n  = S_HEADER;
        space_n  = 1'b0;
        cnt_n    = reload(HDR_MARK);
        env_n    = 1'b1;
        seg0_n   = tx.seg0_data;
        seg1_n   = tx.seg1_data;
      end
    end else if (tx.tx_abort) begin
      state_n = S_IDLE;
      space_n = 1'b0;
      cnt_n   = '0;
      idx_n   = '0;
      env_n   = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_n = cnt_q - CNT_W'(1);
    end else begin
      case (state_q)
        S_HEADER: begin
          if (!space_q) begin
            space_n = 1'b1;
            cnt_n   = reload(HDR_SPACE);
            env_n   = 1'b0;
          end else begin
            state_n = S_SEG0;
            space_n = 1'b0;
            cnt_n   = reload(BIT_MARK);
            env_n   = 1'b1;
            idx_n   = IDX_W'(SEG0_BITS - 1);
          end
        end
        S_SEG0, S_SEG1: begin
          if (!space_q) begin
            space_n = 1'b1;
            cnt_n   = cur_bit_c ? reload(ONE_SPACE) : reload(ZERO_SPACE);
            env_n   = 1'b0;
          end else if (idx_q != '0) begin
            idx_n   = idx_q - IDX_W'(1);
            space_n = 1'b0;
            cnt_n   = reload(BIT_MARK);
            env_n   = 1'b1;
            if (state_q == S_SEG0) seg0_n = seg0_q << 1;
            else                   seg1_n = seg1_q << 1;
          end else if (state_q == S_SEG0 && SEG1_BITS != 0) begin
            state_n = S_CONNECT;
            space_n = 1'b0;
            cnt_n   = reload(CONN_MARK);
            env_n   = 1'b1;
          end else begin
            state_n = S_TRAILER;
            space_n = 1'b0;
            cnt_n   = reload(TRAIL_MARK);
            env_n   = 1'b1;
          end
        end
        S_CONNECT: begin
          if (!space_q) begin
            space_n = 1'b1;
            cnt_n   = reload(CONN_SPACE);
            env_n   = 1'b0;
          end else begin
            state_n = S_SEG1;
            space_n = 1'b0;
            cnt_n   = reload(BIT_MARK);
            env_n   = 1'b1;
            idx_n   = IDX_W'(SEG1_W - 1);
          end
        end
        S_TRAILER: begin
          state_n = S_IDLE;
          space_n = 1'b0;
          env_n   = 1'b0;
          done_n  = 1'b1;
        end
        default: begin
          state_n = S_IDLE;
          space_n = 1'b0;
          env_n   = 1'b0;
        end
      endcase
    end
  end

`ifdef IR_FRAME_TX_CARRIER_EN
  localparam int unsigned CAR_W = $clog2(CARRIER_DIV);

  logic [CAR_W-1:0] car_q, car_n;

  // Free-running carrier phase, restarted so every frame begins on a high half.
  always_comb begin
    car_n = car_q + CAR_W'(1);
    if (accept_c || car_q == CAR_W'(CARRIER_DIV - 1)) car_n = '0;
    ir_n = env_n & (car_n < CAR_W'(CARRIER_HIGH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) car_q <= '0;
    else      car_q <= car_n;
  end
`else
  always_comb ir_n = env_n;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      space_q  <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg0_q   <= '0;
      seg1_q   <= '0;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      envelope <= 1'b0;
      IR_out   <= 1'b0;
    end else begin
      state_q  <= state_n;
      space_q  <= space_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      seg0_q   <= seg0_n;
      seg1_q   <= seg1_n;
      ready_q  <= (state_n == S_IDLE);
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
      envelope <= env_n;
      IR_out   <= ir_n;
    end
  end

endmodule
